// File: rtl/qrow_argmax_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : qrow_argmax_arbiter
// Description : Two-port round-robin Q-table row reader with sequential
//               signed argmax over the four action values of a row.
// Revision    : 1.0 - initial release
// ============================================================================
module qrow_argmax_arbiter #(
  parameter int Q_WIDTH    = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req0,
  input  logic [ADDR_WIDTH-1:0]       addr0,
  input  logic                        req1,
  input  logic [ADDR_WIDTH-1:0]       addr1,
  output logic                        gnt0,
  output logic                        gnt1,
  output logic                        done0,
  output logic                        done1,
  output logic signed [Q_WIDTH-1:0]   max_q,
  output logic [1:0]                  max_act,
  output logic                        busy,
  output logic                        ram_rd_en,
  output logic [ADDR_WIDTH-1:0]       ram_addr,
  input  logic [Q_WIDTH*4-1:0]        ram_rd_data
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_SCAN = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]                r_state;
  logic [2:0]                w_state_nxt;

  logic                      r_sel;
  logic                      r_last_grant;
  logic [ADDR_WIDTH-1:0]     r_addr;
  logic [Q_WIDTH*4-1:0]      r_row;
  logic [1:0]                r_idx;
  logic signed [Q_WIDTH-1:0] r_cur_max;
  logic [1:0]                r_cur_act;

  logic                      w_any_req;
  logic                      w_win_sel;
  logic [ADDR_WIDTH-1:0]     w_win_addr;
  logic signed [Q_WIDTH-1:0] w_q [4];
  logic signed [Q_WIDTH-1:0] w_cand;
  logic signed [Q_WIDTH-1:0] w_scan_max;
  logic [1:0]                w_scan_act;

  // --------------------------------------------------------------------------
  // Arbitration: on contention the port that did not win last time is chosen
  // --------------------------------------------------------------------------
  always_comb begin
    w_any_req = req0 | req1;
    if (req0 && req1) begin
      w_win_sel = ~r_last_grant;
    end else begin
      w_win_sel = req1;
    end
    w_win_addr = w_win_sel ? addr1 : addr0;
  end

  generate
    for (genvar a = 0; a < 4; a++) begin : g_unpack
      assign w_q[a] = r_row[Q_WIDTH*a +: Q_WIDTH];
    end
  endgenerate

  // Strict compare keeps the lower index on ties.
  always_comb begin
    w_cand     = w_q[r_idx];
    w_scan_max = r_cur_max;
    w_scan_act = r_cur_act;
    if (r_idx == 2'd0) begin
      w_scan_max = w_cand;
      w_scan_act = 2'd0;
    end else if (w_cand > r_cur_max) begin
      w_scan_max = w_cand;
      w_scan_act = r_idx;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          w_state_nxt = S_RD;
        end
      end
      S_RD:   w_state_nxt = S_WAIT;
      S_WAIT: w_state_nxt = S_SCAN;
      S_SCAN: begin
        if (r_idx == 2'd3) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs (decoded from registered state only)
  // --------------------------------------------------------------------------
  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    done0     = 1'b0;
    done1     = 1'b0;
    ram_rd_en = 1'b0;
    busy      = (r_state != S_IDLE);
    case (r_state)
      S_RD: begin
        ram_rd_en = 1'b1;
        gnt0      = ~r_sel;
        gnt1      = r_sel;
      end
      S_DONE: begin
        done0 = ~r_sel;
        done1 = r_sel;
      end
      default: ;
    endcase
  end

  assign ram_addr = r_addr;

  // --------------------------------------------------------------------------
  // Request capture
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel        <= 1'b0;
      r_last_grant <= 1'b1;
      r_addr       <= '0;
    end else if (r_state == S_IDLE && w_any_req) begin
      r_sel        <= w_win_sel;
      r_last_grant <= w_win_sel;
      r_addr       <= w_win_addr;
    end
  end

  // --------------------------------------------------------------------------
  // Row capture and sequential scan
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row     <= '0;
      r_idx     <= 2'd0;
      r_cur_max <= '0;
      r_cur_act <= 2'd0;
    end else begin
      if (r_state == S_WAIT) begin
        r_row <= ram_rd_data;
        r_idx <= 2'd0;
      end
      if (r_state == S_SCAN) begin
        r_cur_max <= w_scan_max;
        r_cur_act <= w_scan_act;
        r_idx     <= r_idx + 2'd1;
      end
    end
  end

  // Result registers load on the edge entering DONE and hold until the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_q   <= '0;
      max_act <= 2'd0;
    end else if (r_state == S_SCAN && r_idx == 2'd3) begin
      max_q   <= w_scan_max;
      max_act <= w_scan_act;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_qrow_argmax_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_qrow_argmax_arbiter
// Description : Directed self-checking bench for qrow_argmax_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_qrow_argmax_arbiter;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               req0, req1;
  logic [7:0]         addr0, addr1;
  logic               gnt0, gnt1, done0, done1;
  logic signed [15:0] max_q;
  logic [1:0]         max_act;
  logic               busy, ram_rd_en;
  logic [7:0]         ram_addr;
  logic [63:0]        ram_rd_data;
  logic [63:0]        mem [256];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_rd_en) ram_rd_data <= mem[ram_addr];
  end

  qrow_argmax_arbiter #(.Q_WIDTH(16), .ADDR_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .addr0(addr0), .req1(req1), .addr1(addr1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .max_q(max_q), .max_act(max_act), .busy(busy),
    .ram_rd_en(ram_rd_en), .ram_addr(ram_addr), .ram_rd_data(ram_rd_data)
  );

  typedef struct {
    bit                 p;
    logic [7:0]         addr;
    logic signed [15:0] q0, q1, q2, q3;
    int                 eq;
    int                 ea;
  } vec_t;

  vec_t vecs [8];

  function automatic vec_t mkv(input bit p, input logic [7:0] a,
                               input int q3, input int q2, input int q1, input int q0,
                               input int eq, input int ea);
    vec_t v;
    v.p = p; v.addr = a;
    v.q0 = 16'(q0); v.q1 = 16'(q1); v.q2 = 16'(q2); v.q3 = 16'(q3);
    v.eq = eq; v.ea = ea;
    return v;
  endfunction

  task automatic chk(input string name, input int actual, input int expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // One isolated transaction; starts and ends on a negedge.
  task automatic run_single(input vec_t v, input string tag);
    int  cyc;
    bit  got;
    bit  other_done;
    @(negedge clk);
    if (v.p) begin req1 = 1'b1; addr1 = v.addr; end
    else     begin req0 = 1'b1; addr0 = v.addr; end
    @(negedge clk);
    chk({tag, "_gnt"}, int'(v.p ? gnt1 : gnt0), 1);
    chk({tag, "_gnt_other"}, int'(v.p ? gnt0 : gnt1), 0);
    chk({tag, "_rd_en"}, int'(ram_rd_en), 1);
    chk({tag, "_ram_addr"}, int'(ram_addr), int'(v.addr));
    req0 = 1'b0; req1 = 1'b0;
    cyc = 1; got = 1'b0; other_done = 1'b0;
    while (!got && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (cyc == 2) begin
        chk({tag, "_gnt_pulse"}, int'(gnt0 | gnt1), 0);
        chk({tag, "_rd_en_pulse"}, int'(ram_rd_en), 0);
      end
      if (v.p ? done0 : done1) other_done = 1'b1;
      if (v.p ? done1 : done0) got = 1'b1;
    end
    chk({tag, "_done_seen"}, int'(got), 1);
    chk({tag, "_done_latency"}, cyc, 7);
    chk({tag, "_other_done"}, int'(other_done), 0);
    chk({tag, "_max_q"}, int'(max_q), v.eq);
    chk({tag, "_max_act"}, int'(max_act), v.ea);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int ng, nd, last_c, dp, first_g;
    int gport [4];
    bit seen;

    vecs[0] = mkv(1'b0, 8'h05,      7,     -3,  12,      4,     12, 1);
    vecs[1] = mkv(1'b1, 8'h10, -32768,     -5,  -5,   -100,     -5, 1);
    vecs[2] = mkv(1'b0, 8'h20,      9,      9,   9,      9,      9, 0);
    vecs[3] = mkv(1'b1, 8'h30, -32768, -32768, -32768, -32768, -32768, 0);
    vecs[4] = mkv(1'b0, 8'h40,  32767,      0,   0, -32768,  32767, 3);
    vecs[5] = mkv(1'b1, 8'h41,     -1,     -2,  -3, -32768,     -1, 3);
    vecs[6] = mkv(1'b0, 8'h42,      0,    100,  -1,    100,    100, 0);
    vecs[7] = mkv(1'b1, 8'hFF,      5,      6,  -7, -32768,      6, 2);

    for (int i = 0; i < 256; i++) mem[i] = 64'h0;
    foreach (vecs[i]) mem[vecs[i].addr] = {vecs[i].q3, vecs[i].q2, vecs[i].q1, vecs[i].q0};
    mem[8'h01] = {16'sd3, 16'sd20, 16'sd3, -16'sd1};
    mem[8'h02] = {16'sd50, -16'sd2, 16'sd49, 16'sd0};

    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0;
    repeat (3) @(negedge clk);
    chk("rst_gnt", int'(gnt0 | gnt1), 0);
    chk("rst_done", int'(done0 | done1), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_rd_en", int'(ram_rd_en), 0);
    chk("rst_max_q", int'(max_q), 0);
    chk("rst_max_act", int'(max_act), 0);
    chk("rst_ram_addr", int'(ram_addr), 0);
    rst_n = 1'b1;

    foreach (vecs[i]) run_single(vecs[i], $sformatf("vec%0d", i));

    // Reset during SCAN aborts without a done pulse.
    @(negedge clk);
    req0 = 1'b1; addr0 = 8'h05;
    @(negedge clk);
    chk("rmid_gnt0", int'(gnt0), 1);
    req0 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rmid_busy_before", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("rmid_busy", int'(busy), 0);
    chk("rmid_gnt", int'(gnt0 | gnt1), 0);
    chk("rmid_done", int'(done0 | done1), 0);
    chk("rmid_rd_en", int'(ram_rd_en), 0);
    chk("rmid_max_q", int'(max_q), 0);
    chk("rmid_max_act", int'(max_act), 0);
    chk("rmid_ram_addr", int'(ram_addr), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (done0 || done1 || busy) seen = 1'b1;
    end
    chk("rmid_quiet_after", int'(seen), 0);
    run_single(vecs[0], "rmid_retry");

    // Contention from reset with both requests held.
    @(negedge clk);
    rst_n = 1'b0;
    req0 = 1'b1; addr0 = 8'h01;
    req1 = 1'b1; addr1 = 8'h02;
    @(negedge clk);
    rst_n = 1'b1;
    ng = 0; nd = 0; last_c = 0; first_g = -1;
    for (int i = 0; i < 4; i++) gport[i] = -1;
    for (int c = 1; c <= 45 && nd < 4; c++) begin
      @(negedge clk);
      if (gnt0 || gnt1) begin
        if (first_g < 0) first_g = c;
        if (ng < 4) gport[ng] = gnt1 ? 1 : 0;
        ng++;
        if (ng == 4) begin req0 = 1'b0; req1 = 1'b0; end
      end
      if (done0 || done1) begin
        dp = done1 ? 1 : 0;
        chk($sformatf("cont_done_port%0d", nd), dp, nd % 2);
        chk($sformatf("cont_max_q%0d", nd), int'(max_q), dp ? 50 : 20);
        chk($sformatf("cont_max_act%0d", nd), int'(max_act), dp ? 3 : 2);
        if (nd > 0) chk($sformatf("cont_done_gap%0d", nd), c - last_c, 8);
        last_c = c;
        nd++;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("cont_first_gnt_cycle", first_g, 1);
    chk("cont_grants", ng, 4);
    chk("cont_dones", nd, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("cont_order%0d", i), gport[i], i % 2);

    // Late request from port 1 while port 0 scans; result hold check.
    @(negedge clk);
    req0 = 1'b1; addr0 = 8'h20;
    @(negedge clk);
    chk("late_gnt0", int'(gnt0), 1);
    req0 = 1'b0;
    for (int k = 2; k <= 16; k++) begin
      @(negedge clk);
      chk($sformatf("late_gnt1_k%0d", k), int'(gnt1), (k == 9) ? 1 : 0);
      chk($sformatf("late_done0_k%0d", k), int'(done0), (k == 7) ? 1 : 0);
      chk($sformatf("late_done1_k%0d", k), int'(done1), (k == 15) ? 1 : 0);
      chk($sformatf("late_max_q_k%0d", k), int'(max_q), (k < 7) ? 50 : ((k < 15) ? 9 : 12));
      if (k == 4) begin req1 = 1'b1; addr1 = 8'h05; end
      if (k == 9) req1 = 1'b0;
    end
    chk("late_max_act", int'(max_act), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
